// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// The state encoding, port decode helper and Moore output decode live here.
package router_pkg;

    localparam int          ADDR_W       = 2;
    localparam int          NUM_PORTS    = 3;
    localparam logic [1:0]  ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } fsm_out_t;

    // Per-port flag lookup; the invalid address selects no port.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    addr);
        logic bit_v;
        if (addr == ADDR_INVALID) begin
            bit_v = 1'b0;
        end else begin
            bit_v = vec[addr];
        end
        return bit_v;
    endfunction

    // Moore output decode of a state.
    function automatic fsm_out_t decode_state(input state_t s);
        fsm_out_t o;
        o               = '0;
        o.detect_add    = (s == DECODE_ADDRESS);
        o.lfd_state     = (s == LOAD_FIRST_DATA);
        o.ld_state      = (s == LOAD_DATA);
        o.laf_state     = (s == LOAD_AFTER_FULL);
        o.full_state    = (s == FIFO_FULL_STATE);
        o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
        o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
        return o;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header destination, sequences the
// packet register stage and gates writes into the selected output FIFO.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy
);

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   addr_r;
    fsm_out_t            out_r;

    // Next-state logic; a timeout on the selected FIFO overrides normal flow outside DA.
    always_comb begin
        next_state_s = DECODE_ADDRESS;
        if ((state_r != DECODE_ADDRESS) && port_bit(soft_reset, addr_r)) begin
            next_state_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (pkt_valid && (data_in != ADDR_INVALID)) begin
                        if (port_bit(fifo_empty, data_in)) begin
                            next_state_s = LOAD_FIRST_DATA;
                        end else begin
                            next_state_s = WAIT_TILL_EMPTY;
                        end
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (port_bit(fifo_empty, addr_r)) begin
                        next_state_s = LOAD_FIRST_DATA;
                    end else begin
                        next_state_s = WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: next_state_s = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        next_state_s = LOAD_AFTER_FULL;
                    end else begin
                        next_state_s = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        next_state_s = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                LOAD_PARITY: next_state_s = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                default: next_state_s = DECODE_ADDRESS;
            endcase
        end
    end

    // State and destination registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= DECODE_ADDRESS;
            addr_r  <= 2'd0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == DECODE_ADDRESS) && pkt_valid) begin
                addr_r <= data_in;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Outputs are registered from the next-state decode so they equal the decode of state_r.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r <= decode_state(DECODE_ADDRESS);
        end else begin
            out_r <= decode_state(next_state_s);
        end
    end

    assign detect_add    = out_r.detect_add;
    assign lfd_state     = out_r.lfd_state;
    assign ld_state      = out_r.ld_state;
    assign laf_state     = out_r.laf_state;
    assign full_state    = out_r.full_state;
    assign rst_int_reg   = out_r.rst_int_reg;
    assign write_enb_reg = out_r.write_enb_reg;
    assign busy          = out_r.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios followed by random
// traffic, each edge's expected outputs queued from a behavioural packet model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, write_enb_reg, busy;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    // Packet phases of the model, named after what the router is doing.
    typedef enum {PH_IDLE, PH_WAIT, PH_FIRST, PH_BODY, PH_STALL, PH_RESUME, PH_PARITY, PH_CHECK} phase_t;

    phase_t     phase = PH_IDLE;
    int         dest  = 0;
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Expected {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} for a phase.
    function automatic logic [7:0] expect_of(input phase_t p);
        logic writing, idle_like;
        writing   = (p == PH_BODY) || (p == PH_PARITY) || (p == PH_RESUME);
        idle_like = (p == PH_IDLE) || (p == PH_BODY);
        return {p == PH_IDLE, p == PH_FIRST, p == PH_BODY, p == PH_RESUME,
                p == PH_STALL, p == PH_CHECK, writing, !idle_like};
    endfunction

    task automatic step(input logic pv, input logic [1:0] din, input logic ff,
                        input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                        input logic lpv, input logic rn);
        phase_t nxt;
        pkt_valid = pv; data_in = din; fifo_full = ff; fifo_empty = fe;
        soft_reset = sr; parity_done = pd; low_pkt_valid = lpv; resetn = rn;
        nxt = phase;
        if (!rn) begin
            nxt  = PH_IDLE;
            dest = 0;
        end else if (phase != PH_IDLE && dest < 3 && sr[dest]) begin
            nxt = PH_IDLE;
        end else begin
            case (phase)
                PH_IDLE: if (pv) begin
                    dest = din;
                    if (dest < 3) nxt = fe[dest] ? PH_FIRST : PH_WAIT;
                end
                PH_WAIT:   if (fe[dest]) nxt = PH_FIRST;
                PH_FIRST:  nxt = PH_BODY;
                PH_BODY:   nxt = ff ? PH_STALL : (!pv ? PH_PARITY : PH_BODY);
                PH_STALL:  nxt = ff ? PH_STALL : PH_RESUME;
                PH_RESUME: nxt = pd ? PH_IDLE : (lpv ? PH_PARITY : PH_BODY);
                PH_PARITY: nxt = PH_CHECK;
                PH_CHECK:  nxt = ff ? PH_STALL : PH_IDLE;
                default:   nxt = PH_IDLE;
            endcase
        end
        phase = nxt;
        exp_q.push_back(expect_of(phase));
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected output vector per clock edge, compared on the falling edge.
    always @(negedge clk) begin
        logic [7:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {detect_add, lfd_state, ld_state, laf_state,
                     full_state, rst_int_reg, write_enb_reg, busy};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs @%0t: got %b expected %b (da,lfd,ld,laf,full,rst,we,busy)",
                         $time, act_v, exp_v);
            end
        end
    end

    initial begin
        // Reset
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);

        // Header to empty FIFO1, four valid bytes then parity
        step(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b1);

        // Destination busy: wait, then empty releases it
        step(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);

        // FIFO full in LD, resume to LD, then full again and resume to parity
        repeat (3) step(1'b1, 2'd0, 1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);

        // Invalid destination is dropped
        repeat (5) step(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);

        // Soft reset: other FIFO ignored, selected FIFO aborts the packet
        step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b110, 3'b010, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 1'b1);

        // Reset mid-LD clears state and destination
        step(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut.addr_r !== 2'd0) begin
            n_fail++;
            $display("FAIL addr_after_reset: got %0d expected 0", dut.addr_r);
        end
        step(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 63) != 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
